regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port register file for the pipelined CPU: NUM_RD combinational read ports,
//  two write ports (WB pipe, plus a second WB for long-latency unit), optional same-cycle write->read
//  bypass, and a per-register scoreboard (pending-write bits) the hazard unit uses for stall decisions.
//  Sits between ID (reads, issue) and WB (writes).
// PARAMETERS
//  DW        32  data width in bits
//  AW        5   address width; DEPTH = 2**AW registers
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_REG  1   1: register 0 reads as 0, writes/issues to it ignored; 0: reg 0 is ordinary
//  BYPASS    1   1: read returns data being written this cycle; 0: read returns stored value only
// PORTS
//  clk        in   1          clock; all state updates on rising edge
//  reset      in   1          asynchronous, active-high reset
//  rd_addr    in   NUM_RD*AW  read addresses, port k at [k*AW +: AW]
//  rd_data    out  NUM_RD*DW  read data, port k at [k*DW +: DW]
//  rd_busy    out  NUM_RD     scoreboard pending bit of rd_addr[k] (after bypass rule below)
//  we         in   2          write enables, port 0 / port 1
//  wr_addr    in   2*AW       write addresses, port j at [j*AW +: AW]
//  wr_data    in   2*DW       write data, port j at [j*DW +: DW]
//  iss_valid  in   1          instruction issued that will write iss_addr later
//  iss_addr   in   AW         destination register of issued instruction
//  busy_vec   out  2**AW      full scoreboard, bit r = register r has a pending write
// BEHAVIOUR
//  - Reset (async, asserted): all registers <= 0, all busy bits <= 0 immediately; hence rd_data = 0,
//    rd_busy = 0, busy_vec = 0 while reset high. Reset mid-operation discards pending writes/issues.
//  - Writes: at rising clk, reg[wr_addr[j]] <= wr_data[j] when we[j]. Both ports same address:
//    port 1 wins. If ZERO_REG=1, writes to address 0 are dropped.
//  - Reads: purely combinational, zero latency. ZERO_REG=1 and addr 0 -> 0, no bypass, rd_busy=0.
//    BYPASS=1: if we[1] && wr_addr[1]==rd_addr[k] -> wr_data[1]; else if port 0 matches -> wr_data[0];
//    else stored value. BYPASS=0: always stored value (new value visible the cycle after write).
//  - Scoreboard, per register r, next-state at rising clk:
//      set   = iss_valid && iss_addr==r (and r!=0 when ZERO_REG=1)
//      clear = (we[0] && wr_addr[0]==r) || (we[1] && wr_addr[1]==r)
//      busy[r] <= set ? 1 : clear ? 0 : busy[r]   (set beats clear: new issue is youngest)
//    Issue to an already-busy register keeps it busy (no counting; in-order WAW handled by hazard unit).
//  - rd_busy[k] = busy[rd_addr[k]], except BYPASS=1 and a same-cycle write to rd_addr[k] forces 0
//    (data is being forwarded). busy_vec is the raw registered scoreboard.
//  - Width rules: no truncation/extension; addresses use full AW bits, all DEPTH entries addressable.
//  - No X propagation: unused bits of flattened buses never drive logic outside their slice.
// TESTING
//  1 Reset: preload r5=32'hDEAD_BEEF, assert reset mid-cycle -> rd_data=0, busy_vec=0 immediately.
//  2 Zero reg: we[0]=1, wr_addr=0, wr_data=32'h1234; next cycle read addr 0 -> 0; iss_addr=0 -> busy_vec[0]=0.
//  3 Port conflict: we=2'b11, both addr 7, data 32'hAAAA/32'h5555 -> next cycle r7=32'h5555;
//    same cycle (BYPASS=1) read addr 7 -> 32'h5555; BYPASS=0 -> old r7.
//  4 Scoreboard: issue r9 at cycle 0 -> busy_vec[9]=1 cycle 1, rd_busy=1 on read of 9; write r9=32'h42
//    at cycle 3 -> rd_busy=0 during cycle 3 (BYPASS=1), busy_vec[9]=0 at cycle 4.
//  5 Set beats clear: same cycle iss r3 and we[0] to r3 -> busy_vec[3]=1 next cycle, r3 updated.
//  6 Parameter sweep: NUM_RD=4, DW=16, AW=3: random writes/reads vs reference model, 1000 cycles, 0 mismatches.

Source files
------------

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp_sb
//  Purpose  : Multi-port register file for the pipelined CPU. It has NUM_RD
//             combinational read ports and two write ports: the main WB pipe
//             and a second WB for the long-latency unit. It supports optional
//             same-cycle write->read bypass. A per-register scoreboard holds
//             pending-write bits that the hazard unit uses to decide stalls.
//  Ports    : clk        - clock, all state updates on rising edge
//             reset      - asynchronous active-high reset
//             rd_addr    - NUM_RD read addresses, port k at [k*AW +: AW]
//             rd_data    - NUM_RD read data words, port k at [k*DW +: DW]
//             rd_busy    - pending-write bit seen by each read port
//             we         - write enables for write port 0 and write port 1
//             wr_addr    - write addresses, port j at [j*AW +: AW]
//             wr_data    - write data, port j at [j*DW +: DW]
//             iss_valid  - an issued instruction will later write iss_addr
//             iss_addr   - destination register of the issued instruction
//             busy_vec   - raw registered scoreboard, one bit per register
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*DW-1:0]   rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [1:0]             we,
    input  logic [2*AW-1:0]        wr_addr,
    input  logic [2*DW-1:0]        wr_data,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_addr,
    output logic [(1<<AW)-1:0]     busy_vec
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;

    logic [AW-1:0]    w_wa0;
    logic [AW-1:0]    w_wa1;
    logic [DW-1:0]    w_wd0;
    logic [DW-1:0]    w_wd1;
    logic [1:0]       w_we_eff;

    assign w_wa0 = wr_addr[0 +: AW];
    assign w_wa1 = wr_addr[AW +: AW];
    assign w_wd0 = wr_data[0 +: DW];
    assign w_wd1 = wr_data[DW +: DW];

    // A hard-wired zero register silently drops writes aimed at it.
    assign w_we_eff[0] = we[0] && !((ZERO_REG != 0) && (w_wa0 == '0));
    assign w_we_eff[1] = we[1] && !((ZERO_REG != 0) && (w_wa1 == '0));

    // Storage. Port 1 is applied last so that it wins an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_we_eff[0]) begin
                r_mem[w_wa0] <= w_wd0;
            end
            if (w_we_eff[1]) begin
                r_mem[w_wa1] <= w_wd1;
            end
        end
    end

    // Scoreboard next state. A new issue beats a retiring write to the same
    // register because the issued instruction is the youngest writer.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < DEPTH; r++) begin
            if (iss_valid && (iss_addr == AW'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
                w_busy_nxt[r] = 1'b1;
            end else if ((we[0] && (w_wa0 == AW'(r))) || (we[1] && (w_wa1 == AW'(r)))) begin
                w_busy_nxt[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

    // Read ports
    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [AW-1:0] w_ra;
            logic          w_zero;
            logic          w_hit0;
            logic          w_hit1;

            assign w_ra   = rd_addr[k*AW +: AW];
            assign w_zero = (ZERO_REG != 0) && (w_ra == '0);
            assign w_hit0 = (BYPASS != 0) && we[0] && (w_wa0 == w_ra);
            assign w_hit1 = (BYPASS != 0) && we[1] && (w_wa1 == w_ra);

            // Reset also masks the forwarding path so every read is 0 while
            // reset is held, even if a write is being presented.
            assign rd_data[k*DW +: DW] = (reset || w_zero) ? '0    :
                                         w_hit1            ? w_wd1 :
                                         w_hit0            ? w_wd0 :
                                                             r_mem[w_ra];

            // Data being forwarded this cycle is no longer pending.
            assign rd_busy[k] = !(reset || w_zero || w_hit0 || w_hit1) && r_busy[w_ra];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp_sb
//  Purpose  : Directed self-checking bench for regfile_mp_sb. It uses three
//             instances:
//               u0 - default parameters (bypass on, zero register)
//               u1 - bypass off, driven by the same inputs as u0
//               u2 - NUM_RD=4, DW=16, AW=3, ordinary register 0,
//                    checked against a small reference model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        reset;

    // u0 / u1 shared stimulus
    logic [9:0]  rd_addr0;
    logic [63:0] rd_data0;
    logic [63:0] rd_data1;
    logic [1:0]  rd_busy0;
    logic [1:0]  rd_busy1;
    logic [1:0]  we0;
    logic [9:0]  wr_addr0;
    logic [63:0] wr_data0;
    logic        iss_valid0;
    logic [4:0]  iss_addr0;
    logic [31:0] busy_vec0;
    logic [31:0] busy_vec1;

    // u2 stimulus
    logic [11:0] rd_addr2;
    logic [63:0] rd_data2;
    logic [3:0]  rd_busy2;
    logic [1:0]  we2;
    logic [5:0]  wr_addr2;
    logic [31:0] wr_data2;
    logic        iss_valid2;
    logic [2:0]  iss_addr2;
    logic [7:0]  busy_vec2;

    // u2 reference model
    logic [15:0] m_mem [8];
    logic [7:0]  m_busy;
    logic [15:0] m_exp_d;
    logic        m_exp_b;
    logic [2:0]  m_a;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    regfile_mp_sb u0 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .rd_busy(rd_busy0), .we(we0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .iss_valid(iss_valid0), .iss_addr(iss_addr0), .busy_vec(busy_vec0)
    );

    regfile_mp_sb #(.BYPASS(0)) u1 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr0), .rd_data(rd_data1),
        .rd_busy(rd_busy1), .we(we0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .iss_valid(iss_valid0), .iss_addr(iss_addr0), .busy_vec(busy_vec1)
    );

    regfile_mp_sb #(.DW(16), .AW(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(1)) u2 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .rd_busy(rd_busy2), .we(we2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .iss_valid(iss_valid2), .iss_addr(iss_addr2), .busy_vec(busy_vec2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        rd_addr0   = '0;
        we0        = '0;
        wr_addr0   = '0;
        wr_data0   = '0;
        iss_valid0 = 1'b0;
        iss_addr0  = '0;
        rd_addr2   = '0;
        we2        = '0;
        wr_addr2   = '0;
        wr_data2   = '0;
        iss_valid2 = 1'b0;
        iss_addr2  = '0;
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_busy = '0;

        #1;
        chk("reset_rd_data", rd_data0, 64'h0);
        chk("reset_busy_vec", {32'h0, busy_vec0}, 64'h0);
        #1;
        reset = 1'b0;

        // ---- 1: preload r5 and a pending r12, then reset mid-cycle
        we0 = 2'b01; wr_addr0 = {5'd0, 5'd5}; wr_data0 = {32'h0, 32'hDEAD_BEEF};
        iss_valid0 = 1'b1; iss_addr0 = 5'd12;
        tick();
        we0 = 2'b00; iss_valid0 = 1'b0;
        rd_addr0 = {5'd0, 5'd5};
        #1;
        chk("preload_r5", {32'h0, rd_data0[31:0]}, 64'hDEAD_BEEF);
        chk("preload_busy12", {32'h0, busy_vec0}, 64'h0000_1000);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_rd", {32'h0, rd_data0[31:0]}, 64'h0);
        chk("async_reset_busy", {32'h0, busy_vec0}, 64'h0);
        chk("async_reset_rd_nobyp", {32'h0, rd_data1[31:0]}, 64'h0);
        #1;
        reset = 1'b0;

        // ---- 2: zero register ignores writes and issues
        tick();
        we0 = 2'b01; wr_addr0 = {5'd0, 5'd0}; wr_data0 = {32'h0, 32'h1234};
        iss_valid0 = 1'b1; iss_addr0 = 5'd0;
        rd_addr0 = {5'd0, 5'd0};
        #1;
        chk("zero_no_bypass", {32'h0, rd_data0[31:0]}, 64'h0);
        tick();
        we0 = 2'b00; iss_valid0 = 1'b0;
        #1;
        chk("zero_read", {32'h0, rd_data0[31:0]}, 64'h0);
        chk("zero_busy", {32'h0, busy_vec0}, 64'h0);

        // ---- 3: write-port conflict, bypass on vs off
        we0 = 2'b01; wr_addr0 = {5'd0, 5'd7}; wr_data0 = {32'h0, 32'h1111};
        tick();
        we0 = 2'b11; wr_addr0 = {5'd7, 5'd7}; wr_data0 = {32'h5555, 32'hAAAA};
        rd_addr0 = {5'd7, 5'd7};
        #1;
        chk("conflict_bypass", {32'h0, rd_data0[31:0]}, 64'h5555);
        chk("conflict_nobypass_old", {32'h0, rd_data1[31:0]}, 64'h1111);
        tick();
        we0 = 2'b00;
        #1;
        chk("conflict_stored", {32'h0, rd_data0[63:32]}, 64'h5555);
        chk("conflict_stored_nobyp", {32'h0, rd_data1[31:0]}, 64'h5555);
        we0 = 2'b01; wr_addr0 = {5'd0, 5'd7}; wr_data0 = {32'h0, 32'h7777};
        #1;
        chk("port0_bypass", {32'h0, rd_data0[63:32]}, 64'h7777);
        chk("port0_nobypass_old", {32'h0, rd_data1[63:32]}, 64'h5555);
        tick();
        we0 = 2'b00;

        // ---- 4: scoreboard set, forward clears rd_busy, write clears busy
        iss_valid0 = 1'b1; iss_addr0 = 5'd9;
        tick();
        iss_valid0 = 1'b0;
        rd_addr0 = {5'd9, 5'd1};
        #1;
        chk("sb_busy_vec9", {32'h0, busy_vec0}, 64'h0000_0200);
        chk("sb_rd_busy", {62'h0, rd_busy0}, 64'h2);
        tick();
        tick();
        we0 = 2'b01; wr_addr0 = {5'd0, 5'd9}; wr_data0 = {32'h0, 32'h42};
        #1;
        chk("sb_fwd_rd_busy", {62'h0, rd_busy0}, 64'h0);
        chk("sb_fwd_data", {32'h0, rd_data0[63:32]}, 64'h42);
        chk("sb_nobyp_rd_busy", {62'h0, rd_busy1}, 64'h2);
        chk("sb_still_busy", {32'h0, busy_vec0}, 64'h0000_0200);
        tick();
        we0 = 2'b00;
        #1;
        chk("sb_cleared", {32'h0, busy_vec0}, 64'h0);
        chk("sb_r9_data", {32'h0, rd_data0[63:32]}, 64'h42);

        // ---- 5: set beats clear, then clear via write port 1
        iss_valid0 = 1'b1; iss_addr0 = 5'd3;
        we0 = 2'b01; wr_addr0 = {5'd0, 5'd3}; wr_data0 = {32'h0, 32'h33};
        tick();
        iss_valid0 = 1'b0; we0 = 2'b00;
        rd_addr0 = {5'd0, 5'd3};
        #1;
        chk("setclr_busy", {32'h0, busy_vec0}, 64'h0000_0008);
        chk("setclr_data", {32'h0, rd_data0[31:0]}, 64'h33);
        we0 = 2'b10; wr_addr0 = {5'd3, 5'd0}; wr_data0 = {32'h44, 32'h0};
        tick();
        we0 = 2'b00;
        #1;
        chk("clr_port1_busy", {32'h0, busy_vec0}, 64'h0);
        chk("clr_port1_data", {32'h0, rd_data0[31:0]}, 64'h44);

        // ---- 6: parameter sweep against the reference model
        for (int c = 0; c < 1000; c++) begin
            we2        = 2'($urandom_range(0, 3));
            wr_addr2   = 6'($urandom_range(0, 63));
            wr_data2   = $urandom;
            iss_valid2 = 1'($urandom_range(0, 1));
            iss_addr2  = 3'($urandom_range(0, 7));
            rd_addr2   = 12'($urandom_range(0, 4095));
            #1;
            chk("sweep_busy_vec", {56'h0, busy_vec2}, {56'h0, m_busy});
            for (int k = 0; k < 4; k++) begin
                m_a = rd_addr2[k*3 +: 3];
                if (we2[1] && wr_addr2[5:3] == m_a) begin
                    m_exp_d = wr_data2[31:16]; m_exp_b = 1'b0;
                end else if (we2[0] && wr_addr2[2:0] == m_a) begin
                    m_exp_d = wr_data2[15:0];  m_exp_b = 1'b0;
                end else begin
                    m_exp_d = m_mem[m_a];      m_exp_b = m_busy[m_a];
                end
                chk("sweep_rd_data", {48'h0, rd_data2[k*16 +: 16]}, {48'h0, m_exp_d});
                chk("sweep_rd_busy", {63'h0, rd_busy2[k]}, {63'h0, m_exp_b});
            end
            for (int r = 0; r < 8; r++) begin
                if (iss_valid2 && iss_addr2 == 3'(r)) begin
                    m_busy[r] = 1'b1;
                end else if ((we2[0] && wr_addr2[2:0] == 3'(r)) || (we2[1] && wr_addr2[5:3] == 3'(r))) begin
                    m_busy[r] = 1'b0;
                end
            end
            if (we2[0]) m_mem[wr_addr2[2:0]] = wr_data2[15:0];
            if (we2[1]) m_mem[wr_addr2[5:3]] = wr_data2[31:16];
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
